xnor_resp_checker: RTL and testbench

//   Synthesizable response checker at the far end of the gate-test interface: watches the

---
 rtl/gate_chk_pkg.sv | 10 +
 rtl/xnor_resp_checker_settle_timer.sv | 27 ++
 rtl/xnor_resp_checker.sv | 107 ++++++++++
 tb/tb_xnor_resp_checker.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate-test response checker: FSM encoding and settle counter width.
package gate_chk_pkg;
    localparam int SET_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/xnor_resp_checker_settle_timer.sv
// Down-counter that measures how long the current input vector has been stable.
module settle_timer
    import gate_chk_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SET_W-1:0] ld_val,
    output logic             expired
);

    logic [SET_W-1:0] cnt_q;

    // Free-running between loads; every entry to checking reloads it, so idling is harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= ld_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/xnor_resp_checker.sv
// Checks a gate-under-test output against XNOR once per settled input vector and keeps results.
module xnor_resp_checker
    import gate_chk_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             a,
    input  logic             b,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err_flag,
    output logic [2:0]       first_err_vec,
    output logic [3:0]       coverage
);

    state_t           state_q;
    logic             busy_q, done_q, pending_q, err_q;
    logic [1:0]       prev_ab_q;
    logic [CNT_W-1:0] pass_q, fail_q;
    logic [2:0]       first_q;
    logic [3:0]       cov_q;
    logic [1:0]       ab;
    logic             load, expired, exp_y;

    assign ab    = {a, b};
    assign exp_y = ~(a ^ b);

    // The timer restarts on entry to RUN and whenever the vector changes; stop overrides a change.
    assign load = (state_q != ST_RUN) ? start : (!stop && (ab != prev_ab_q));

    settle_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .ld_val  (SET_W'(SETTLE)),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pending_q <= 1'b0;
            prev_ab_q <= 2'b00;
            pass_q    <= '0;
            fail_q    <= '0;
            err_q     <= 1'b0;
            first_q   <= 3'b000;
            cov_q     <= 4'b0000;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (stop) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (ab != prev_ab_q) begin
                        prev_ab_q <= ab;
                        pending_q <= 1'b1;
                    end else if (expired && pending_q) begin
                        pending_q     <= 1'b0;
                        cov_q[ab]     <= 1'b1;
                        if (y == exp_y) begin
                            if (pass_q != '1) pass_q <= pass_q + CNT_W'(1);
                        end else begin
                            if (fail_q != '1) fail_q <= fail_q + CNT_W'(1);
                            err_q <= 1'b1;
                            if (!err_q) first_q <= {a, b, y};
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state_q   <= ST_RUN;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        pending_q <= 1'b1;
                        prev_ab_q <= ab;
                        pass_q    <= '0;
                        fail_q    <= '0;
                        err_q     <= 1'b0;
                        first_q   <= 3'b000;
                        cov_q     <= 4'b0000;
                    end
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass_cnt      = pass_q;
    assign fail_cnt      = fail_q;
    assign err_flag      = err_q;
    assign first_err_vec = first_q;
    assign coverage      = cov_q;

endmodule

// File: tb/tb_xnor_resp_checker.sv
// Bench for xnor_resp_checker: three parameterisations share one stimulus stream against a vector-age model.
module tb_xnor_resp_checker;

    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, stop = 1'b0, a = 1'b0, b = 1'b0, y = 1'b1;

    logic       busy0, done0, err0, busy1, done1, err1, busy2, done2, err2;
    logic [7:0] pass0, fail0, pass1, fail1;
    logic [1:0] pass2, fail2;
    logic [2:0] first0, first1, first2;
    logic [3:0] cov0, cov1, cov2;

    int checks = 0;
    int errors = 0;
    bit compareEn = 1'b0;

    always #5 clk = ~clk;

    // Instance 0: SETTLE=2 CNT_W=8, instance 1: SETTLE=0 CNT_W=8, instance 2: SETTLE=2 CNT_W=2.
    xnor_resp_checker #(.CNT_W(8), .SETTLE(2)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .a(a), .b(b), .y(y),
        .busy(busy0), .done(done0), .pass_cnt(pass0), .fail_cnt(fail0),
        .err_flag(err0), .first_err_vec(first0), .coverage(cov0));

    xnor_resp_checker #(.CNT_W(8), .SETTLE(0)) dutS0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .a(a), .b(b), .y(y),
        .busy(busy1), .done(done1), .pass_cnt(pass1), .fail_cnt(fail1),
        .err_flag(err1), .first_err_vec(first1), .coverage(cov1));

    xnor_resp_checker #(.CNT_W(2), .SETTLE(2)) dutC2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .a(a), .b(b), .y(y),
        .busy(busy2), .done(done2), .pass_cnt(pass2), .fail_cnt(fail2),
        .err_flag(err2), .first_err_vec(first2), .coverage(cov2));

    // Model: a vector is checked on the (SETTLE+1)-th edge it has been seen unchanged.
    int mSettle[3] = '{2, 0, 2};
    int mMax[3]    = '{255, 255, 3};
    int mRun[3], mDone[3], mAb[3], mAge[3], mPass[3], mFail[3], mErr[3], mFirst[3], mCov[3];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                mRun[k] = 0; mDone[k] = 0; mAb[k] = 0; mAge[k] = 0;
                mPass[k] = 0; mFail[k] = 0; mErr[k] = 0; mFirst[k] = 0; mCov[k] = 0;
            end else if (mRun[k] == 0) begin
                if (start) begin
                    mRun[k] = 1; mDone[k] = 0; mAb[k] = a * 2 + b; mAge[k] = 0;
                    mPass[k] = 0; mFail[k] = 0; mErr[k] = 0; mFirst[k] = 0; mCov[k] = 0;
                end
            end else if (stop) begin
                mRun[k] = 0; mDone[k] = 1;
            end else if (a * 2 + b != mAb[k]) begin
                mAb[k] = a * 2 + b; mAge[k] = 0;
            end else begin
                mAge[k]++;
                if (mAge[k] == mSettle[k] + 1) begin
                    mCov[k] = mCov[k] | (1 << (a * 2 + b));
                    if (int'(y) == ((a == b) ? 1 : 0)) begin
                        if (mPass[k] < mMax[k]) mPass[k]++;
                    end else begin
                        if (mFail[k] < mMax[k]) mFail[k]++;
                        if (mErr[k] == 0) mFirst[k] = a * 4 + b * 2 + y;
                        mErr[k] = 1;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (compareEn) begin
            int bs[3], dn[3], ps[3], fl[3], er[3], fe[3], cv[3];
            bs = '{int'(busy0), int'(busy1), int'(busy2)};
            dn = '{int'(done0), int'(done1), int'(done2)};
            ps = '{int'(pass0), int'(pass1), int'(pass2)};
            fl = '{int'(fail0), int'(fail1), int'(fail2)};
            er = '{int'(err0), int'(err1), int'(err2)};
            fe = '{int'(first0), int'(first1), int'(first2)};
            cv = '{int'(cov0), int'(cov1), int'(cov2)};
            for (int k = 0; k < 3; k++) begin
                checkOutput($sformatf("model busy[%0d]", k), bs[k], mRun[k]);
                checkOutput($sformatf("model done[%0d]", k), dn[k], mDone[k]);
                checkOutput($sformatf("model pass[%0d]", k), ps[k], mPass[k]);
                checkOutput($sformatf("model fail[%0d]", k), fl[k], mFail[k]);
                checkOutput($sformatf("model err[%0d]", k), er[k], mErr[k]);
                checkOutput($sformatf("model first[%0d]", k), fe[k], mFirst[k]);
                checkOutput($sformatf("model cov[%0d]", k), cv[k], mCov[k]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic aa, input logic bb, input logic yy, input int n);
        a = aa; b = bb; y = yy;
        step(n);
    endtask

    task automatic startRun(input logic aa, input logic bb, input logic yy, input int n);
        a = aa; b = bb; y = yy; start = 1'b1;
        step(1);
        start = 1'b0;
        if (n > 1) step(n - 1);
    endtask

    task automatic stopRun();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        compareEn = 1'b1;
        checkOutput("reset busy", busy0, 0);
        checkOutput("reset pass", pass0, 0);

        $display("[TB] golden run over all four vectors");
        startRun(0, 0, 1, 5);
        applyStimulus(0, 1, 0, 5);
        applyStimulus(1, 0, 0, 5);
        applyStimulus(1, 1, 1, 5);
        stopRun();
        checkOutput("golden pass", pass0, 4);
        checkOutput("golden fail", fail0, 0);
        checkOutput("golden cov", cov0, 15);
        checkOutput("golden err", err0, 0);
        checkOutput("golden done", done0, 1);
        checkOutput("golden pass cnt2", pass2, 3);

        $display("[TB] faulty y at 00 and 11");
        startRun(0, 0, 0, 5);
        applyStimulus(0, 1, 0, 5);
        applyStimulus(1, 0, 0, 5);
        applyStimulus(1, 1, 0, 5);
        stopRun();
        checkOutput("fault fail", fail0, 2);
        checkOutput("fault pass", pass0, 2);
        checkOutput("fault err", err0, 1);
        checkOutput("fault first", first0, 0);

        $display("[TB] glitching inputs");
        startRun(0, 0, 1, 2);
        checkOutput("restart clears err", err0, 0);
        checkOutput("restart clears fail", fail0, 0);
        applyStimulus(0, 1, 0, 2);
        applyStimulus(1, 0, 0, 2);
        applyStimulus(0, 1, 0, 2);
        applyStimulus(0, 0, 1, 2);
        applyStimulus(1, 1, 1, 5);
        stopRun();
        checkOutput("glitch pass", pass0, 1);
        checkOutput("glitch cov", cov0, 8);
        checkOutput("glitch pass settle0", pass1, 6);
        checkOutput("glitch cov settle0", cov1, 15);

        $display("[TB] saturation with narrow counters");
        startRun(0, 0, 1, 5);
        applyStimulus(0, 1, 0, 5);
        applyStimulus(1, 0, 0, 5);
        applyStimulus(1, 1, 1, 5);
        applyStimulus(0, 0, 1, 5);
        stopRun();
        checkOutput("sat pass cnt2", pass2, 3);
        checkOutput("sat fail cnt2", fail2, 0);
        checkOutput("sat pass wide", pass0, 5);

        $display("[TB] reset in the middle of a run");
        startRun(0, 0, 1, 5);
        applyStimulus(0, 1, 0, 5);
        checkOutput("pre-reset pass", pass0, 2);
        rst = 1'b1;
        step(1);
        checkOutput("mid reset busy", busy0, 0);
        checkOutput("mid reset pass", pass0, 0);
        rst = 1'b0;
        startRun(0, 0, 1, 3);
        checkOutput("post reset pass early", pass0, 0);
        step(1);
        checkOutput("post reset pass", pass0, 1);

        $display("[TB] start and stop together");
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        a = 1'b0; b = 1'b0; y = 1'b1; start = 1'b1; stop = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b0;
        checkOutput("start wins in idle", busy0, 1);
        step(2);
        start = 1'b1; stop = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b0;
        checkOutput("stop wins in run", done0, 1);
        checkOutput("discarded check", pass0, 0);
        checkOutput("settle0 checked", pass1, 1);
        startRun(0, 0, 1, 1);
        checkOutput("second start clears", pass1, 0);
        step(4);

        compareEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
